// File: rtl/sccomp_pkg.sv
// Shared decode constants, ALU/immediate/writeback enums and the immediate generator
// for the single-cycle RV32I-subset computer.
package sccomp_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_SW   = 3'b010;
    localparam logic [2:0] F3_JALR = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_SLT,
        ALU_SLTU,
        ALU_LUI_PASS
    } alu_op_t;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_type_t;

    typedef enum logic [1:0] {
        WB_ALU,
        WB_MEM,
        WB_PC4
    } wb_sel_t;

    // B and J immediates are already scaled by 2, so they add directly to the PC.
    function automatic logic [31:0] immGen(input logic [31:0] instr, input imm_type_t immType);
        logic [31:0] imm;
        case (immType)
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = {{20{instr[31]}}, instr[31:20]};
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/sc_alu.sv
// 32-bit ALU: result of a op b plus a zero flag used for beq/bne.
module sc_alu
    import sccomp_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  alu_op_t     op_i,
    output logic [31:0] result_o,
    output logic        zero_o
);

    always_comb begin
        result_o = '0;
        case (op_i)
            ALU_ADD:      result_o = a_i + b_i;
            ALU_SUB:      result_o = a_i - b_i;
            ALU_AND:      result_o = a_i & b_i;
            ALU_OR:       result_o = a_i | b_i;
            ALU_XOR:      result_o = a_i ^ b_i;
            ALU_SLL:      result_o = a_i << b_i[4:0];
            ALU_SRL:      result_o = a_i >> b_i[4:0];
            ALU_SRA:      result_o = $unsigned($signed(a_i) >>> b_i[4:0]);
            ALU_SLT:      result_o = {31'b0, $signed(a_i) < $signed(b_i)};
            ALU_SLTU:     result_o = {31'b0, a_i < b_i};
            ALU_LUI_PASS: result_o = b_i;
            default:      result_o = '0;
        endcase
    end

    assign zero_o = (result_o == 32'd0);

endmodule

// File: rtl/sc_imem.sv
// Instruction ROM: combinational word read, contents loaded from outside (never reset).
module sc_imem #(
    parameter int DEPTH = 128,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic [AW-1:0] addr_i,
    output logic [31:0]   instr_o
);

    logic [31:0] ROM [DEPTH];

    assign instr_o = ROM[addr_i];

endmodule

// File: rtl/single_cycle_comp.sv
// Single-cycle RV32I-subset computer: one instruction retires per rising clk edge.
// Define SCCOMP_DATA_MEM_EN to build the data RAM; otherwise lw returns 0 and sw is a NOP.
module single_cycle_comp
    import sccomp_pkg::*;
#(
    parameter int          IM_DEPTH = 128,
    parameter int          DM_DEPTH = 128,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [4:0]  reg_sel,
    output logic [31:0] reg_data
);

    localparam int IM_AW = $clog2(IM_DEPTH);

    logic [31:0] pc_q, pc_d;
    logic [31:0] regFile_q [32];
    logic [31:0] instr, imm, rs1Val, rs2Val;
    logic [31:0] aluA, aluB, aluResult, memRdata, wbData, pcPlus4, pcTarget;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic        aluZero, regWrite, useImm, usePcA;
    logic        isBranch, brUseZero, brInvert, isJal, isJalr, branchTaken;
    alu_op_t     aluOp;
    imm_type_t   immType;
    wb_sel_t     wbSel;
`ifdef SCCOMP_DATA_MEM_EN
    logic        memWrite;
`endif

    sc_imem #(.DEPTH(IM_DEPTH)) U_IM (
        .addr_i  (pc_q[IM_AW+1:2]),
        .instr_o (instr)
    );

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    // Anything not explicitly matched below keeps every default and so behaves as a NOP.
    always_comb begin
        aluOp     = ALU_ADD;
        immType   = IMM_I;
        wbSel     = WB_ALU;
        regWrite  = 1'b0;
        useImm    = 1'b0;
        usePcA    = 1'b0;
        isBranch  = 1'b0;
        brUseZero = 1'b0;
        brInvert  = 1'b0;
        isJal     = 1'b0;
        isJalr    = 1'b0;
`ifdef SCCOMP_DATA_MEM_EN
        memWrite  = 1'b0;
`endif
        case (opcode)
            OP_R: begin
                if (funct7 == F7_BASE) begin
                    regWrite = 1'b1;
                    case (funct3)
                        F3_ADD:  aluOp = ALU_ADD;
                        F3_SLL:  aluOp = ALU_SLL;
                        F3_SLT:  aluOp = ALU_SLT;
                        F3_SLTU: aluOp = ALU_SLTU;
                        F3_XOR:  aluOp = ALU_XOR;
                        F3_SR:   aluOp = ALU_SRL;
                        F3_OR:   aluOp = ALU_OR;
                        default: aluOp = ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
                    regWrite = 1'b1;
                    aluOp    = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == F3_SR) begin
                    regWrite = 1'b1;
                    aluOp    = ALU_SRA;
                end
            end
            OP_I: begin
                useImm   = 1'b1;
                regWrite = 1'b1;
                case (funct3)
                    F3_ADD:  aluOp = ALU_ADD;
                    F3_SLT:  aluOp = ALU_SLT;
                    F3_SLTU: aluOp = ALU_SLTU;
                    F3_XOR:  aluOp = ALU_XOR;
                    F3_OR:   aluOp = ALU_OR;
                    F3_AND:  aluOp = ALU_AND;
                    F3_SLL: begin
                        aluOp    = ALU_SLL;
                        regWrite = (funct7 == F7_BASE);
                    end
                    default: begin
                        aluOp    = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        regWrite = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    end
                endcase
            end
            OP_LOAD: begin
                if (funct3 == F3_LW) begin
                    useImm   = 1'b1;
                    regWrite = 1'b1;
                    wbSel    = WB_MEM;
                end
            end
            OP_STORE: begin
                immType = IMM_S;
                useImm  = 1'b1;
`ifdef SCCOMP_DATA_MEM_EN
                memWrite = (funct3 == F3_SW);
`endif
            end
            OP_BRANCH: begin
                immType = IMM_B;
                case (funct3)
                    F3_BEQ: begin isBranch = 1'b1; aluOp = ALU_SUB; brUseZero = 1'b1; end
                    F3_BNE: begin isBranch = 1'b1; aluOp = ALU_SUB; brUseZero = 1'b1; brInvert = 1'b1; end
                    F3_BLT: begin isBranch = 1'b1; aluOp = ALU_SLT; end
                    F3_BGE: begin isBranch = 1'b1; aluOp = ALU_SLT; brInvert = 1'b1; end
                    default: isBranch = 1'b0;
                endcase
            end
            OP_LUI: begin
                immType  = IMM_U;
                useImm   = 1'b1;
                aluOp    = ALU_LUI_PASS;
                regWrite = 1'b1;
            end
            OP_AUIPC: begin
                immType  = IMM_U;
                useImm   = 1'b1;
                usePcA   = 1'b1;
                regWrite = 1'b1;
            end
            OP_JAL: begin
                immType  = IMM_J;
                isJal    = 1'b1;
                regWrite = 1'b1;
                wbSel    = WB_PC4;
            end
            OP_JALR: begin
                if (funct3 == F3_JALR) begin
                    useImm   = 1'b1;
                    isJalr   = 1'b1;
                    regWrite = 1'b1;
                    wbSel    = WB_PC4;
                end
            end
            default: regWrite = 1'b0;
        endcase
    end

    assign imm      = immGen(instr, immType);
    assign rs1Val   = (rs1 == 5'd0) ? 32'd0 : regFile_q[rs1];
    assign rs2Val   = (rs2 == 5'd0) ? 32'd0 : regFile_q[rs2];
    assign reg_data = (reg_sel == 5'd0) ? 32'd0 : regFile_q[reg_sel];
    assign aluA     = usePcA ? pc_q : rs1Val;
    assign aluB     = useImm ? imm : rs2Val;

    sc_alu U_ALU (
        .a_i      (aluA),
        .b_i      (aluB),
        .op_i     (aluOp),
        .result_o (aluResult),
        .zero_o   (aluZero)
    );

`ifdef SCCOMP_DATA_MEM_EN
    localparam int DM_AW = $clog2(DM_DEPTH);
    logic [31:0] dataMem_q [DM_DEPTH];

    always_ff @(posedge clk) begin
        if (!rstn && memWrite) begin
            dataMem_q[aluResult[DM_AW+1:2]] <= rs2Val;
        end
    end

    assign memRdata = dataMem_q[aluResult[DM_AW+1:2]];
`else
    assign memRdata = 32'd0;
`endif

    // Branches reuse the ALU: SUB's zero flag for eq/ne, SLT's bit 0 for lt/ge.
    assign branchTaken = isBranch && ((brUseZero ? aluZero : aluResult[0]) ^ brInvert);
    assign pcPlus4     = pc_q + 32'd4;
    assign pcTarget    = pc_q + imm;

    always_comb begin
        pc_d = pcPlus4;
        if (isJalr) begin
            pc_d = {aluResult[31:1], 1'b0};
        end else if (isJal || branchTaken) begin
            pc_d = pcTarget;
        end
    end

    always_comb begin
        case (wbSel)
            WB_MEM:  wbData = memRdata;
            WB_PC4:  wbData = pcPlus4;
            default: wbData = aluResult;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // x0 is cleared on reset and never written, so it stays zero for good.
    always_ff @(posedge clk) begin
        if (rstn) begin
            for (int i = 0; i < 32; i++) begin
                regFile_q[i] <= 32'd0;
            end
        end else if (regWrite && rd != 5'd0) begin
            regFile_q[rd] <= wbData;
        end
    end

endmodule

// File: tb/tb_single_cycle_comp.sv
// Scoreboard bench for single_cycle_comp: directed program, expected register/PC values queued
// by the stimulus and compared by a negedge monitor. Honours SCCOMP_DATA_MEM_EN for the lw result.
module tb_single_cycle_comp;

    logic        clk = 1'b0;
    logic        rstn;
    logic [4:0]  reg_sel;
    logic [31:0] reg_data;

    int checkCount = 0;
    int failCount  = 0;

    string       nameQ[$];
    logic        isPcQ[$];
    logic [31:0] expQ[$];

    logic [31:0] prog [33] = '{
        32'h00700013, 32'h00500093, 32'h00409113, 32'h001091B3,  // 00: addi x0 / addi x1 / slli x2 / sll x3
        32'hFF800213, 32'h40125293, 32'h01C25313, 32'h123453B7,  // 10: addi x4 / srai x5 / srli x6 / lui x7
        32'h008005EF, 32'h00100613, 32'h67838393, 32'hFFFFF437,  // 20: jal x11,+8 / skipped / addi x7 / lui x8
        32'h00702423, 32'h00802483, 32'h00108463, 32'h00100513,  // 30: sw / lw x9 / beq +8 / skipped
        32'h401386B3, 32'h00122733, 32'h001237B3, 32'h0083C833,  // 40: sub x13 / slt x14 / sltu x15 / xor x16
        32'h00001897, 32'h00109463, 32'h00300913, 32'h00124463,  // 50: auipc x17 / bne not taken / addi x18 / blt +8
        32'h00900993, 32'h07000A67, 32'h00100A93, 32'h00200A93,  // 60: skipped / jalr x20,0x70 / skipped / skipped
        32'h0040D463, 32'h00100B13, 32'h0300EB93, 32'hFFFFFFFF,  // 70: bge +8 / skipped / ori x23 / illegal
        32'h0000006F                                             // 80: jal x0,0 (park)
    };

    single_cycle_comp dut (
        .clk      (clk),
        .rstn     (rstn),
        .reg_sel  (reg_sel),
        .reg_data (reg_data)
    );

    always #5 clk = ~clk;

    // Hand-computed architectural state once the program has parked at 0x80.
    function automatic logic [31:0] golden(input int r);
        case (r)
            1:  return 32'h0000_0005;
            2:  return 32'h0000_0050;
            3:  return 32'h0000_00A0;
            4:  return 32'hFFFF_FFF8;
            5:  return 32'hFFFF_FFFC;
            6:  return 32'h0000_000F;
            7:  return 32'h1234_5678;
            8:  return 32'hFFFF_F000;
`ifdef SCCOMP_DATA_MEM_EN
            9:  return 32'h1234_5678;
`else
            9:  return 32'h0000_0000;
`endif
            11: return 32'h0000_0024;
            13: return 32'h1234_5673;
            14: return 32'h0000_0001;
            16: return 32'hEDCB_A678;
            17: return 32'h0000_1050;
            18: return 32'h0000_0003;
            20: return 32'h0000_0068;
            23: return 32'h0000_0035;
            default: return 32'h0000_0000;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (expQ.size() != 0) begin
            string       n;
            logic        p;
            logic [31:0] e;
            logic [31:0] act;
            n   = nameQ.pop_front();
            p   = isPcQ.pop_front();
            e   = expQ.pop_front();
            act = p ? dut.pc_q : reg_data;
            checkOutput(n, act, e);
        end
    end

    task automatic applyStimulus(input string name, input logic isPc, input logic [4:0] sel,
                                 input logic [31:0] expected);
        reg_sel = sel;
        nameQ.push_back(name);
        isPcQ.push_back(isPc);
        expQ.push_back(expected);
        for (int k = 0; k < 4 && expQ.size() != 0; k++) begin
            @(negedge clk);
            #1;
        end
        if (expQ.size() != 0) begin
            failCount++;
            $display("[TB] FAIL %s: monitor did not consume entry, pending=%0d expected 0", name, expQ.size());
            nameQ.delete();
            isPcQ.delete();
            expQ.delete();
        end
    endtask

    task automatic runCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkFinal(input string tag);
        for (int r = 0; r < 24; r++) begin
            applyStimulus($sformatf("%s x%0d", tag, r), 1'b0, 5'(r), golden(r));
        end
        applyStimulus($sformatf("%s pc", tag), 1'b1, 5'd0, 32'h0000_0080);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rstn    = 1'b1;
        reg_sel = 5'd0;
        for (int i = 0; i < 128; i++) begin
            dut.U_IM.ROM[i] = (i < 33) ? prog[i] : 32'h0000_0013;
        end

        // Reset held for two edges; state is stable while rstn stays high.
        runCycles(2);
        applyStimulus("reset pc", 1'b1, 5'd0, 32'h0);
        for (int r = 1; r < 32; r++) begin
            applyStimulus($sformatf("reset x%0d", r), 1'b0, 5'(r), 32'h0);
        end

        rstn = 1'b0;
        runCycles(40);
        checkFinal("run1");

        // Restart, let six instructions retire, then pulse reset for a single edge.
        rstn = 1'b1;
        runCycles(1);
        rstn = 1'b0;
        runCycles(6);
        applyStimulus("mid x1", 1'b0, 5'd1, 32'h5);
        rstn = 1'b1;
        runCycles(1);
        rstn = 1'b0;
        applyStimulus("restart pc", 1'b1, 5'd0, 32'h0);
        applyStimulus("restart x7", 1'b0, 5'd7, 32'h0);
        applyStimulus("restart x13", 1'b0, 5'd13, 32'h0);
        applyStimulus("restart x23", 1'b0, 5'd23, 32'h0);
        runCycles(40);
        checkFinal("run2");

        if (expQ.size() != 0) begin
            failCount++;
            $display("[TB] FAIL drain: pending=%0d expected 0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", checkCount, failCount);
        $finish;
    end

endmodule
